icache_refill_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 15 +
 rtl/icache_refill_ctrl_if.sv | 21 ++
 rtl/sat_counter.sv | 18 +
 rtl/icache_refill_ctrl.sv | 111 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and default sizes for the RISC-V core; the I-cache refill
// controller uses the refill FSM state type and the cache/bus geometry.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST,
        DONE
    } refill_state_t;

    localparam int ICACHE_BLOCK_BYTES = 64;
    localparam int MEM_WORD_BITS      = 64;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Backing-memory burst read bus between the I-cache refill controller
// (master) and the memory (slave).
interface icache_refill_ctrl_if #(
    parameter int WORD_BITS = 64
);
    logic                 MemReq;
    logic [31:0]          MemAddr;
    logic                 MemGnt;
    logic                 MemRValid;
    logic [WORD_BITS-1:0] MemRData;

    modport master (
        output MemReq, MemAddr,
        input  MemGnt, MemRValid, MemRData
    );

    modport slave (
        input  MemReq, MemAddr,
        output MemGnt, MemRValid, MemRData
    );
endinterface

// File: rtl/sat_counter.sv
// 32-bit saturating event counter with synchronous active-high clear.
module sat_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    output logic [31:0] o_count
);
    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_inc && (r_count != 32'hFFFF_FFFF))
            r_count <= r_count + 32'd1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one burst read per miss, beats forwarded
// to the cache one cycle after arrival. ICACHE_REFILL_PERF_EN adds perf counters.
module icache_refill_ctrl
    import riscv_pkg::*;
#(
    parameter int BLOCK_BYTES = ICACHE_BLOCK_BYTES,
    parameter int WORD_BITS   = MEM_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 InstrMissF,
    input  logic [31:0]          PCF,
    icache_refill_ctrl_if.master mem,
    output logic                 RepReady,
    output logic [WORD_BITS-1:0] RepWord,
    output logic                 RefillBusy
`ifdef ICACHE_REFILL_PERF_EN
   ,output logic [31:0]          RefillCount,
    output logic [31:0]          RefillStallCycles
`endif
);
    localparam int BEATS       = BLOCK_BYTES * 8 / WORD_BITS;
    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    refill_state_t              r_state;
    refill_state_t              w_state_nxt;
    logic [31-OFFSET_BITS:0]    r_line_addr;
    logic [CNT_W-1:0]           r_beat_cnt;
    logic                       r_rep_ready;
    logic [WORD_BITS-1:0]       r_rep_word;
    logic                       w_latch;
    logic                       w_beat;
    logic                       w_last_beat;
    logic                       w_unused_pc_offset;

    assign w_beat      = (r_state == BURST) && mem.MemRValid;
    assign w_last_beat = w_beat && (r_beat_cnt == LAST_BEAT);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (InstrMissF) begin
                    w_state_nxt = REQ;
                    w_latch     = 1'b1;
                end
            end
            // Grant takes priority over a miss withdrawn in the same cycle.
            REQ: begin
                if (mem.MemGnt)
                    w_state_nxt = BURST;
                else if (!InstrMissF)
                    w_state_nxt = IDLE;
            end
            BURST: begin
                if (w_last_beat)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_line_addr <= '0;
            r_beat_cnt  <= '0;
            r_rep_ready <= 1'b0;
            r_rep_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch)
                r_line_addr <= PCF[31:OFFSET_BITS];
            // The exit to DONE on the last beat stops the counter before it wraps.
            if ((r_state == REQ) && mem.MemGnt)
                r_beat_cnt <= '0;
            else if (w_beat && !w_last_beat)
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            r_rep_ready <= w_beat;
            if (w_beat)
                r_rep_word <= mem.MemRData;
        end
    end

    assign mem.MemReq         = (r_state == REQ);
    assign mem.MemAddr        = {r_line_addr, {OFFSET_BITS{1'b0}}};
    assign RepReady           = r_rep_ready;
    assign RepWord            = r_rep_word;
    assign RefillBusy         = (r_state != IDLE);
    assign w_unused_pc_offset = ^PCF[OFFSET_BITS-1:0];

`ifdef ICACHE_REFILL_PERF_EN
    sat_counter u_refill_count (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_last_beat),
        .o_count (RefillCount)
    );

    sat_counter u_stall_count (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (RefillBusy),
        .o_count (RefillStallCycles)
    );
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed + randomized bench for icache_refill_ctrl against a
// transaction-level expectation of the refill protocol.
module tb_icache_refill_ctrl;
    localparam int BLOCK = 64;
    localparam int NBEAT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss;
    logic [31:0] pcf;
    logic        rep_ready;
    logic [63:0] rep_word;
    logic        busy;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] refill_count;
    logic [31:0] stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_done = 0;

    icache_refill_ctrl_if #(.WORD_BITS(64)) mem_bus ();

    icache_refill_ctrl #(.BLOCK_BYTES(BLOCK), .WORD_BITS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .InstrMissF (miss),
        .PCF        (pcf),
        .mem        (mem_bus),
        .RepReady   (rep_ready),
        .RepWord    (rep_word),
        .RefillBusy (busy)
`ifdef ICACHE_REFILL_PERF_EN
       ,.RefillCount       (refill_count),
        .RefillStallCycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic m, input logic [31:0] pc, input logic g,
                       input logic v, input logic [63:0] d);
        miss              = m;
        pcf               = pc;
        mem_bus.MemGnt    = g;
        mem_bus.MemRValid = v;
        mem_bus.MemRData  = d;
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps
    task automatic refill(input logic [31:0] pc, input int gdelay, input int gap_mode,
                          input bit drop_with_gnt, input int rst_after,
                          input bit miss_in_done, input logic [31:0] next_pc,
                          input bit seq_data);
        logic [31:0] exp_addr;
        logic [63:0] d;
        logic        v;
        int          sent;
        int          pulses;
        int          k;
        exp_addr = pc & ~(BLOCK - 1);

        cyc(1'b1, pc, 1'b0, 1'($urandom), {$urandom, $urandom});
        chk("req_rise", 64'(mem_bus.MemReq), 64'd1);
        chk("req_addr", 64'(mem_bus.MemAddr), 64'(exp_addr));
        chk("req_busy", 64'(busy), 64'd1);
        chk("req_noreply", 64'(rep_ready), 64'd0);

        for (int i = 0; i < gdelay; i++) begin
            cyc(1'b1, $urandom, 1'b0, 1'($urandom), {$urandom, $urandom});
            chk("req_hold", 64'(mem_bus.MemReq), 64'd1);
            chk("req_addr_stable", 64'(mem_bus.MemAddr), 64'(exp_addr));
            chk("req_stray_beat", 64'(rep_ready), 64'd0);
        end

        cyc(!drop_with_gnt, pc, 1'b1, 1'b0, 64'd0);
        chk("gnt_req_drop", 64'(mem_bus.MemReq), 64'd0);
        chk("gnt_busy", 64'(busy), 64'd1);

        sent   = 0;
        pulses = 0;
        k      = 0;
        while (sent < NBEAT) begin
            if (rst_after >= 0 && sent == rst_after) begin
                reset = 1'b1;
                cyc(1'($urandom), pc, 1'b0, 1'b1, {$urandom, $urandom});
                reset = 1'b0;
                exp_done = 0;
                chk("rst_rep_ready", 64'(rep_ready), 64'd0);
                chk("rst_rep_word", rep_word, 64'd0);
                chk("rst_memreq", 64'(mem_bus.MemReq), 64'd0);
                chk("rst_memaddr", 64'(mem_bus.MemAddr), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    cyc(1'b0, pc, 1'b0, 1'b1, {$urandom, $urandom});
                    chk("rst_stale_beat", 64'(rep_ready), 64'd0);
                    chk("rst_stale_busy", 64'(busy), 64'd0);
                end
                return;
            end
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = (k > 100) || ($urandom_range(99) >= 40);
            endcase
            d = seq_data ? 64'(sent) : {$urandom, $urandom};
            cyc(1'($urandom), $urandom, 1'b0, v, d);
            chk("beat_ready", 64'(rep_ready), 64'(v));
            if (v) begin
                chk("beat_word", rep_word, d);
                sent++;
            end
            if (rep_ready) pulses++;
            chk("burst_busy", 64'(busy), 64'd1);
            chk("burst_noreq", 64'(mem_bus.MemReq), 64'd0);
            k++;
        end
        chk("pulse_count", 64'(pulses), 64'(NBEAT));
        exp_done++;

        cyc(miss_in_done, miss_in_done ? next_pc : pc, 1'b0, 1'($urandom), {$urandom, $urandom});
        chk("done_idle_busy", 64'(busy), 64'd0);
        chk("done_idle_ready", 64'(rep_ready), 64'd0);
        chk("done_miss_ignored", 64'(mem_bus.MemReq), 64'd0);
    endtask

    task automatic abort(input logic [31:0] pc, input int drop_cycle, input int total);
        cyc(1'b1, pc, 1'b0, 1'b0, 64'd0);
        chk("abort_req", 64'(mem_bus.MemReq), 64'd1);
        for (int i = 1; i <= total; i++) begin
            cyc(i < drop_cycle, pc, 1'b0, 1'($urandom), {$urandom, $urandom});
            chk("abort_req_state", 64'(mem_bus.MemReq), 64'(i < drop_cycle));
            chk("abort_busy", 64'(busy), 64'(i < drop_cycle));
            chk("abort_noreply", 64'(rep_ready), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        chk("reset_memreq", 64'(mem_bus.MemReq), 64'd0);
        chk("reset_memaddr", 64'(mem_bus.MemAddr), 64'd0);
        chk("reset_rep_ready", 64'(rep_ready), 64'd0);
        chk("reset_rep_word", rep_word, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 64'hDEAD);
        chk("idle_stray_beat", 64'(rep_ready), 64'd0);

        refill(32'h0000_1234, 1, 0, 1'b0, -1, 1'b0, 32'd0, 1'b1);
        refill(32'h0000_5678, 0, 1, 1'b0, -1, 1'b0, 32'd0, 1'b0);
        abort(32'h0000_2000, 3, 5);
        refill(32'h0000_3000, 2, 0, 1'b1, -1, 1'b0, 32'd0, 1'b0);
        refill(32'h0000_4000, 0, 0, 1'b0, 3, 1'b0, 32'd0, 1'b0);
        refill(32'h0000_0040, 0, 0, 1'b0, -1, 1'b0, 32'd0, 1'b0);
        refill(32'h0000_1000, 0, 2, 1'b0, -1, 1'b1, 32'h0000_0080, 1'b0);
        refill(32'h0000_0080, 0, 0, 1'b0, -1, 1'b0, 32'd0, 1'b0);
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_refill_count", 64'(refill_count), 64'(exp_done));
`endif

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(3) == 0)
                abort($urandom, $urandom_range(1, 4), 5);
            else
                refill($urandom, $urandom_range(0, 4), $urandom_range(0, 2),
                       1'($urandom), -1, 1'b0, 32'd0, 1'b0);
        end
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_refill_count_end", 64'(refill_count), 64'(exp_done));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
